// File: rtl/wrr_prio_update_ctrl.sv
// Buffered priority-table controller: queues SET/ADD/SUB/RESET updates in a
// small FIFO and applies the head entry to the registered table on commit_en.
module wrr_prio_update_ctrl #(
  parameter int N          = 32,
  parameter int PRIORITY_W = 4,
  parameter int ID_BITS    = $clog2(N),
  parameter int DEPTH      = 4,
  parameter int RESET_PRIO = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prio_upt,
  output logic                          prio_rdy,
  input  logic [ID_BITS-1:0]            prio_id,
  input  logic [PRIORITY_W-1:0]         prio,
  input  logic [1:0]                    prio_op,
  input  logic                          commit_en,
  output logic [N*PRIORITY_W-1:0]       prio_table,
  output logic [N-1:0]                  prio_chg,
  output logic                          upd_err,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_cnt,
  output logic                          busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ID_BITS:0]      N_LIM    = (ID_BITS + 1)'(N);
  localparam logic [PRIORITY_W-1:0] RST_VAL  = PRIORITY_W'(RESET_PRIO);
  localparam logic [PRIORITY_W-1:0] MAX_VAL  = '1;

  typedef enum logic [1:0] {
    OP_SET   = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_RESET = 2'b11
  } op_e;

  logic [ID_BITS-1:0]    fifo_id_q  [DEPTH];
  logic [PRIORITY_W-1:0] fifo_val_q [DEPTH];
  op_e                   fifo_op_q  [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [PRIORITY_W-1:0] table_q [N];
  logic [PRIORITY_W-1:0] table_d [N];
  logic [N-1:0]          chg_q, chg_d;
  logic                  err_q, err_d;

  logic                  xfer, in_range, push, pop;
  logic [ID_BITS-1:0]    head_id;
  logic [PRIORITY_W-1:0] head_val, cur_val, new_val;
  op_e                   head_op;
  logic [PRIORITY_W:0]   sum;

  // Handshake: an update transfers on a rising edge where prio_upt && prio_rdy;
  // prio_rdy comes only from registered occupancy (and rst), never from prio_upt.
  assign prio_rdy = rst && (cnt_q != FULL_CNT);

  always_comb begin
    xfer     = prio_upt && prio_rdy;
    in_range = ({1'b0, prio_id} < N_LIM);
    push     = xfer && in_range;
    pop      = commit_en && (cnt_q != '0);
    head_id  = fifo_id_q[rd_ptr_q];
    head_val = fifo_val_q[rd_ptr_q];
    head_op  = fifo_op_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = xfer && !in_range;
  end

  // Read-modify-write of the targeted entry; sum is one bit wider to detect saturation.
  always_comb begin
    cur_val = '0;
    for (int i = 0; i < N; i++) begin
      if (head_id == ID_BITS'(i)) cur_val = table_q[i];
    end
    sum = {1'b0, cur_val} + {1'b0, head_val};
    case (head_op)
      OP_SET:  new_val = head_val;
      OP_ADD:  new_val = sum[PRIORITY_W] ? MAX_VAL : sum[PRIORITY_W-1:0];
      OP_SUB:  new_val = (head_val > cur_val) ? '0 : cur_val - head_val;
      default: new_val = RST_VAL;
    endcase
  end

  always_comb begin
    chg_d = '0;
    for (int i = 0; i < N; i++) begin
      table_d[i] = table_q[i];
      if (pop && (head_id == ID_BITS'(i))) begin
        table_d[i] = new_val;
        chg_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]  <= prio_id;
      fifo_val_q[wr_ptr_q] <= prio;
      fifo_op_q[wr_ptr_q]  <= op_e'(prio_op);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      chg_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < N; i++) table_q[i] <= RST_VAL;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
      for (int i = 0; i < N; i++) table_q[i] <= table_d[i];
    end
  end

  always_comb begin
    prio_table = '0;
    for (int i = 0; i < N; i++) prio_table[i*PRIORITY_W +: PRIORITY_W] = table_q[i];
  end

  assign prio_chg = chg_q;
  assign upd_err  = err_q;
  assign fifo_cnt = cnt_q;
  assign busy     = (cnt_q != '0);

endmodule
